// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and counter sizing helper
package uart_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Tick counter must reach 15 in DATA and SB_TICK-1 in STOP without wrapping.
  function automatic int tick_cnt_width(input int sb_tick);
    return (sb_tick > 16) ? $clog2(sb_tick) : 4;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial input and received-word signals of the UART receiver
interface uart_receiver_if
  import uart_pkg::*;
#(
  parameter int DBIT = DBIT_DEF
) (
  input logic clk
);

  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] rx_dout;
  logic            rx_done_tick;
  logic            frame_error;
  logic            busy;

  modport master (
    input  clk,
    output s_tick, rx,
    input  rx_dout, rx_done_tick, frame_error, busy
  );

  modport slave (
    input  clk,
    input  s_tick, rx,
    output rx_dout, rx_done_tick, frame_error, busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer with selectable reset value
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic areset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x-oversampled UART receiver with start validation and frame error flag
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_error,
  output logic            busy
);

  localparam int S_W = tick_cnt_width(SB_TICK);
  localparam int N_W = $clog2(DBIT);

  localparam logic [S_W-1:0] S_ONE  = S_W'(1);
  localparam logic [S_W-1:0] S_MID  = S_W'(7);
  localparam logic [S_W-1:0] S_BIT  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_ONE  = N_W'(1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

  logic            rxs;
  logic [1:0]      state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .areset (areset),
    .d_i    (rx),
    .q_o    (rxs)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    case (state_q)
      ST_IDLE: begin
        // Start detection ignores s_tick so the tick phase begins at the falling edge.
        if (!rxs) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rxs) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rxs, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + N_ONE;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            dout_d  = b_q;
            ferr_d  = ~rxs;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign frame_error  = ferr_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver with randomized frames
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int DBIT    = DBIT_DEF;
  localparam int SB_TICK = SB_TICK_DEF;
  localparam int LAT     = 8 + 16 * DBIT + SB_TICK;

  typedef struct {
    logic [DBIT-1:0] data;
    logic            ferr;
    int              t0;
  } exp_t;

  logic clk    = 1'b0;
  logic areset = 1'b0;
  bit   tick_en = 1'b1;
  int   tick_num = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  uart_receiver_if #(.DBIT(DBIT)) bus (.clk(clk));

  uart_receiver #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk          (clk),
    .areset       (areset),
    .s_tick       (bus.s_tick),
    .rx           (bus.rx),
    .rx_dout      (bus.rx_dout),
    .rx_done_tick (bus.rx_done_tick),
    .frame_error  (bus.frame_error),
    .busy         (bus.busy)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int ph;
    ph = 0;
    bus.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      if (tick_en && ph == 0) begin
        bus.s_tick = 1'b1;
        tick_num++;
      end else begin
        bus.s_tick = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      int g;
      g = 0;
      @(posedge clk);
      while (!bus.s_tick && g < 64) begin
        @(posedge clk);
        g++;
      end
      if (g >= 64) begin
        checks++;
        errors++;
        $display("FAIL tick_timeout actual=none required=s_tick at %0t", $time);
      end
    end
    #1;
  endtask

  // ev_kind: 0 plain, 1 freeze ticks mid bit ev_bit, 2 reset mid bit ev_bit (frame abandoned)
  task automatic send_frame(input logic [DBIT-1:0] d, input logic stop, input int ev_bit, input int ev_kind);
    sb.push_back('{data: d, ferr: ~stop, t0: tick_num});
    bus.rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < DBIT; i++) begin
      bus.rx = d[i];
      if (i == ev_bit && ev_kind == 1) begin
        wait_ticks(8);
        tick_en = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("freeze_busy", 32'(bus.busy), 32'd1);
        check("freeze_no_done", 32'(bus.rx_done_tick), 32'd0);
        tick_en = 1'b1;
        wait_ticks(8);
      end else if (i == ev_bit && ev_kind == 2) begin
        wait_ticks(8);
        areset = 1'b0;
        sb.delete(sb.size() - 1);
        bus.rx = 1'b1;
        @(posedge clk);
        #1;
        check("rst_dout", 32'(bus.rx_dout), 32'd0);
        check("rst_ferr", 32'(bus.frame_error), 32'd0);
        check("rst_done", 32'(bus.rx_done_tick), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        areset = 1'b1;
        return;
      end else begin
        wait_ticks(16);
      end
    end
    // Stop is held only up to its sampling tick so the next start can follow with no gap.
    bus.rx = stop;
    wait_ticks(SB_TICK - 8);
    bus.rx = 1'b1;
  endtask

  initial begin : monitor
    exp_t            e;
    logic            prev_done;
    logic [DBIT-1:0] last_dout;
    logic            last_ferr;
    bit              hold_bad;
    prev_done = 1'b0;
    last_dout = '0;
    last_ferr = 1'b0;
    hold_bad  = 1'b0;
    forever begin
      @(negedge clk);
      if (!areset) begin
        prev_done = 1'b0;
        last_dout = bus.rx_dout;
        last_ferr = bus.frame_error;
        hold_bad  = 1'b0;
        continue;
      end
      if (prev_done) check("done_width", 32'(bus.rx_done_tick), 32'd0);
      if (bus.rx_done_tick) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done actual=pulse required=none dout=%0h at %0t", bus.rx_dout, $time);
        end else begin
          e = sb.pop_front();
          check("rx_dout", 32'(bus.rx_dout), 32'(e.data));
          check("frame_error", 32'(bus.frame_error), 32'(e.ferr));
          check("latency", 32'(tick_num - e.t0), 32'(LAT));
          check("hold_between", 32'(hold_bad), 32'd0);
        end
        hold_bad = 1'b0;
      end else if (bus.rx_dout !== last_dout || bus.frame_error !== last_ferr) begin
        hold_bad = 1'b1;
      end
      last_dout = bus.rx_dout;
      last_ferr = bus.frame_error;
      prev_done = bus.rx_done_tick;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [DBIT-1:0] d;
    logic            stop;
    bus.rx = 1'b1;
    areset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 32'(bus.rx_dout), 32'd0);
    check("reset_ferr", 32'(bus.frame_error), 32'd0);
    check("reset_done", 32'(bus.rx_done_tick), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    areset = 1'b1;
    wait_ticks(4);

    send_frame(8'hA5, 1'b1, -1, 0);
    wait_ticks(4);

    bus.rx = 1'b0;
    wait_ticks(2);
    check("fstart_busy_early", 32'(bus.busy), 32'd1);
    wait_ticks(1);
    bus.rx = 1'b1;
    wait_ticks(4);
    check("fstart_busy_t7", 32'(bus.busy), 32'd1);
    wait_ticks(2);
    check("fstart_busy_drop", 32'(bus.busy), 32'd0);
    wait_ticks(4);

    send_frame(8'h3C, 1'b0, -1, 0);
    wait_ticks(16);
    send_frame(8'h81, 1'b1, -1, 0);
    wait_ticks(4);

    send_frame(8'hC3, 1'b1, 4, 2);
    wait_ticks(8);
    send_frame(8'h55, 1'b1, -1, 0);
    wait_ticks(4);

    send_frame(8'h00, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b1, -1, 0);
    wait_ticks(4);

    send_frame(8'h6B, 1'b1, 3, 1);
    wait_ticks(4);

    for (int i = 0; i < 8; i++) begin
      d    = DBIT'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop, -1, 0);
      wait_ticks(stop ? int'($urandom_range(0, 3)) : 16);
    end

    wait_ticks(20);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
